// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use / mult-div stall control for the ID stage.
// One compare slice per ID source; the shared mult/div and statistics state live in the top.

module fwd_src_cmp #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  output logic [1:0]        sel,
  output logic              luh
);
  logic ex_hit, mem_hit;

  // A zero Rd never matches, so source register 0 always reads the register file.
  assign ex_hit  = ex_reg_write  && (ex_rd  != '0) && (ex_rd  == src);
  assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src);

  always_comb begin
    sel = 2'd0;
    if (ex_hit)       sel = 2'd2;
    else if (mem_hit) sel = 2'd1;
  end

  assign luh = ex_hit && ex_mem_read && used;
endmodule

module fwd_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_md_use,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_md_start,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_reg_write,
  input  logic                      stat_clr,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      pc_hold,
  output logic                      ifid_hold,
  output logic                      idex_flush,
  output logic                      md_busy,
  output logic                      md_err,
  output logic [CNT_W-1:0]          stall_cnt
);
  localparam int MD_CW = $clog2(MD_LAT + 1);

  logic [NUM_SRC-1:0] luh_v;
  logic               luh, mdh, stall;
  logic [MD_CW-1:0]   md_cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_cmp #(.REG_AW(REG_AW)) u_cmp (
      .src           (id_src[i*REG_AW +: REG_AW]),
      .used          (id_src_used[i]),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .sel           (fwd_sel[2*i +: 2]),
      .luh           (luh_v[i])
    );
  end

  assign luh        = |luh_v;
  assign md_busy    = (md_cnt != '0);
  assign mdh        = md_busy && id_md_use;
  assign stall      = luh || mdh;
  assign pc_hold    = stall;
  assign ifid_hold  = stall;
  assign idex_flush = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_cnt    <= '0;
      md_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      // A start while busy is an error and must not extend the current operation.
      if (md_cnt == '0) begin
        if (ex_md_start) md_cnt <= MD_CW'(MD_LAT);
      end else begin
        md_cnt <= md_cnt - MD_CW'(1);
        if (ex_md_start) md_err <= 1'b1;
      end

      if (stat_clr)                       stall_cnt <= '0;
      else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: vector table through a scoreboard queue, then
// hand-written mult/div, saturation and asynchronous-reset sequences.

module tb_fwd_hazard_unit;
  localparam int REG_AW = 5, NUM_SRC = 2, MD_LAT = 4, CNT_W = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0] id_src_used;
  logic id_md_use, ex_reg_write, ex_mem_read, ex_md_start, mem_reg_write, stat_clr;
  logic [REG_AW-1:0] ex_rd, mem_rd;
  logic [2*NUM_SRC-1:0] fwd_sel;
  logic pc_hold, ifid_hold, idex_flush, md_busy, md_err;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_used(id_src_used), .id_md_use(id_md_use),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_md_start(ex_md_start), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .stat_clr(stat_clr), .fwd_sel(fwd_sel), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .idex_flush(idex_flush), .md_busy(md_busy), .md_err(md_err), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [4:0] s0, s1;
    logic [1:0] used;
    logic [4:0] ex_rd;
    logic       ex_rw, ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [3:0] sel;
    logic       stall;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic       stall;
    logic [3:0] cnt;
  } exp_t;

  vec_t vecs[11];
  exp_t q[$];
  exp_t e;
  logic [3:0] exp_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_src = '0; id_src_used = '0; id_md_use = 0; ex_rd = '0; ex_reg_write = 0;
    ex_mem_read = 0; ex_md_start = 0; mem_rd = '0; mem_reg_write = 0; stat_clr = 0;
  endtask

  task automatic chk_stall(input string nm, input logic exp);
    chk({nm, "_pc_hold"}, 32'(pc_hold), 32'(exp));
    chk({nm, "_ifid_hold"}, 32'(ifid_hold), 32'(exp));
    chk({nm, "_idex_flush"}, 32'(idex_flush), 32'(exp));
  endtask

  initial begin
    //            s0  s1  used   exrd rw mr memrd mrw  sel      stall
    vecs[0]  = '{ 8,  9, 2'b11,  8,  1, 0,  8,  1, 4'b0010, 0}; // EX beats MEM
    vecs[1]  = '{ 8,  9, 2'b11,  8,  0, 0,  8,  1, 4'b0001, 0}; // EX gated off
    vecs[2]  = '{ 0,  7, 2'b11,  0,  1, 0,  7,  0, 4'b0000, 0}; // zero reg, MEM gated
    vecs[3]  = '{ 6,  5, 2'b11,  5,  1, 0,  6,  1, 4'b1001, 0}; // mixed per source
    vecs[4]  = '{ 4,  3, 2'b10,  3,  1, 1,  0,  0, 4'b1000, 1}; // load-use on src1
    vecs[5]  = '{ 4,  3, 2'b01,  3,  1, 1,  0,  0, 4'b1000, 0}; // src1 not read
    vecs[6]  = '{ 3,  3, 2'b01,  3,  1, 1,  0,  0, 4'b1010, 1}; // load-use on src0
    vecs[7]  = '{ 3,  3, 2'b11,  3,  0, 1,  0,  0, 4'b0000, 0}; // load without write
    vecs[8]  = '{ 0,  0, 2'b11,  0,  1, 1,  0,  0, 4'b0000, 0}; // load to r0
    vecs[9]  = '{12, 12, 2'b00, 12,  1, 0,  0,  0, 4'b1010, 0}; // fwd ignores used
    vecs[10] = '{31, 31, 2'b11, 30,  1, 0, 31,  1, 4'b0101, 0}; // MEM only

    idle();
    #12;
    chk("rst_md_busy", 32'(md_busy), 0);
    chk("rst_md_err", 32'(md_err), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk_stall("rst", 1'b0);
    @(negedge clk) rst = 1'b1;

    // Table vectors through the scoreboard
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      id_src = {vecs[i].s1, vecs[i].s0}; id_src_used = vecs[i].used;
      ex_rd = vecs[i].ex_rd; ex_reg_write = vecs[i].ex_rw; ex_mem_read = vecs[i].ex_mr;
      mem_rd = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_rw;
      q.push_back('{vecs[i].sel, vecs[i].stall, exp_cnt});
      if (vecs[i].stall && exp_cnt != 4'hf) exp_cnt = exp_cnt + 4'd1;
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("vec%0d_fwd_sel", i), 32'(fwd_sel), 32'(e.sel));
      chk_stall($sformatf("vec%0d", i), e.stall);
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(e.cnt));
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("table_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // Clear statistics
    @(posedge clk); #1 stat_clr = 1;
    @(posedge clk); #1 stat_clr = 0;
    @(negedge clk) chk("clr_stall_cnt", 32'(stall_cnt), 0);

    // Mult/div with the ID instruction waiting on HI/LO
    @(posedge clk); #1 ex_md_start = 1; id_md_use = 1;
    @(negedge clk);
    chk("md0_busy", 32'(md_busy), 0);
    chk_stall("md0", 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1 ex_md_start = 0;
      @(negedge clk);
      chk($sformatf("md%0d_busy", c), 32'(md_busy), 32'(c <= 4));
      chk_stall($sformatf("md%0d", c), c <= 4);
    end
    chk("md_stall_cnt", 32'(stall_cnt), 4);
    chk("md_err_clean", 32'(md_err), 0);
    id_md_use = 0;

    // Second start while busy: error, no reload
    @(posedge clk); #1 ex_md_start = 1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1 ex_md_start = (c == 2);
      @(negedge clk);
      if (c == 2) chk("mderr_before", 32'(md_err), 0);
      if (c >= 3) chk($sformatf("mderr%0d_err", c), 32'(md_err), 1);
      chk($sformatf("mderr%0d_busy", c), 32'(md_busy), 32'(c <= 4));
    end

    // Saturation of the statistics counter, then clear against a live stall
    @(posedge clk); #1 stat_clr = 1;
    @(posedge clk); #1 stat_clr = 0;
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd3; id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 10) chk("sat10_cnt", 32'(stall_cnt), 10);
      if (c == 15) chk("sat15_cnt", 32'(stall_cnt), 15);
      if (c == 20) chk("sat20_cnt", 32'(stall_cnt), 15);
    end
    stat_clr = 1;
    @(posedge clk); @(negedge clk) chk("clr_vs_stall_cnt", 32'(stall_cnt), 0);
    stat_clr = 0;
    @(posedge clk); @(negedge clk) chk("post_clr_cnt", 32'(stall_cnt), 1);

    // Asynchronous reset in the middle of a mult/div
    @(posedge clk); #1 idle(); ex_md_start = 1; id_md_use = 1;
    @(posedge clk); #1 ex_md_start = 0;
    @(negedge clk);
    chk("prerst_busy", 32'(md_busy), 1);
    chk("prerst_err", 32'(md_err), 1);
    @(posedge clk); #2 rst = 0;
    #1;
    chk("async_busy", 32'(md_busy), 0);
    chk("async_err", 32'(md_err), 0);
    chk("async_cnt", 32'(stall_cnt), 0);
    chk_stall("async", 1'b0);
    @(negedge clk) rst = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("postrst%0d_busy", c), 32'(md_busy), 0);
      chk_stall($sformatf("postrst%0d", c), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
